// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding / load-use hazard unit.
//   fwd_sel_t   : EX operand bypass select (regfile, MEM result, WB result)
//   haz_state_t : load-use stall FSM states
//   REG_ZERO    : hard-wired zero register address, never a forwarding source
package fwd_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      HZ_IDLE = 1'b0,
      HZ_WAIT = 1'b1
   } haz_state_t;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: bypass select for one EX-stage source operand.
//   i_ex_r              EX-stage source register address
//   i_mem_rw/i_mem_wr   MEM-stage destination and write enable
//   i_wb_rw/i_wb_wr     WB-stage destination and write enable
//   o_sel               fwd_sel_t encoding; MEM wins over WB (younger result)
module fwd_sel
   import fwd_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_ex_r,
   input  logic [REG_AW-1:0] i_mem_rw,
   input  logic              i_mem_wr,
   input  logic [REG_AW-1:0] i_wb_rw,
   input  logic              i_wb_wr,
   output logic [1:0]        o_sel
);

   localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(REG_ZERO);

   logic     w_mem_hit;
   logic     w_wb_hit;
   fwd_sel_t w_sel;

   assign w_mem_hit = i_mem_wr && (i_mem_rw != ZERO_A) && (i_mem_rw == i_ex_r);
   assign w_wb_hit  = i_wb_wr  && (i_wb_rw  != ZERO_A) && (i_wb_rw  == i_ex_r);

   always_comb begin
      w_sel = FWD_REG;
      if (w_mem_hit)
         w_sel = FWD_MEM;
      else if (w_wb_hit)
         w_sel = FWD_WB;
   end

   assign o_sel = w_sel;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects plus load-use stall control.
//   clk, rst_n                 clock (rising edge), async active-low reset
//   Id_Rs/Id_Rt/Id_UsesRt      ID-stage sources
//   Ex_Rs/Ex_Rt/Ex_Rw/Ex_MemRead  EX-stage sources, destination, load flag
//   Mem_Rw/Mem_RegWr, Wr_Rw/Wr_RegWr  MEM/WB writeback candidates
//   Flush                      taken branch/jump; cancels any load-use stall
//   ALUSrcA/ALUSrcB/ALUSrcDin  bypass selects (Din mirrors B)
//   Pc_Stall/IfId_Stall/IdEx_Flush  load-use stall, held LOAD_LAT cycles
// Optional feature macro HAZ_STATS_EN adds saturating Stall_Cnt / Fwd_Cnt.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] Id_Rs,
   input  logic [REG_AW-1:0] Id_Rt,
   input  logic              Id_UsesRt,
   input  logic [REG_AW-1:0] Ex_Rs,
   input  logic [REG_AW-1:0] Ex_Rt,
   input  logic [REG_AW-1:0] Ex_Rw,
   input  logic              Ex_MemRead,
   input  logic [REG_AW-1:0] Mem_Rw,
   input  logic              Mem_RegWr,
   input  logic [REG_AW-1:0] Wr_Rw,
   input  logic              Wr_RegWr,
   input  logic              Flush,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ALUSrcDin,
   output logic              Pc_Stall,
   output logic              IfId_Stall,
   output logic              IdEx_Flush
`ifdef HAZ_STATS_EN
  ,output logic [15:0]       Stall_Cnt,
   output logic [15:0]       Fwd_Cnt
`endif
);

   localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(REG_ZERO);
   localparam logic [CNT_W-1:0]  LAT_M1 = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);

   logic [1:0]       w_sel_a;
   logic [1:0]       w_sel_b;
   logic             w_haz;
   logic             w_stall;
   haz_state_t       r_state;
   haz_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // ---------------- forwarding ----------------
   fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
      .i_ex_r   (Ex_Rs),
      .i_mem_rw (Mem_Rw),
      .i_mem_wr (Mem_RegWr),
      .i_wb_rw  (Wr_Rw),
      .i_wb_wr  (Wr_RegWr),
      .o_sel    (w_sel_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
      .i_ex_r   (Ex_Rt),
      .i_mem_rw (Mem_Rw),
      .i_mem_wr (Mem_RegWr),
      .i_wb_rw  (Wr_Rw),
      .i_wb_wr  (Wr_RegWr),
      .o_sel    (w_sel_b)
   );

   // Outputs are forced low while reset is asserted, including the purely
   // combinational selects, so the pipeline sees a quiet unit during reset.
   assign ALUSrcA   = rst_n ? w_sel_a : 2'b00;
   assign ALUSrcB   = rst_n ? w_sel_b : 2'b00;
   assign ALUSrcDin = ALUSrcB;

   // ---------------- load-use hazard ----------------
   assign w_haz = Ex_MemRead && (Ex_Rw != ZERO_A) &&
                  ((Ex_Rw == Id_Rs) || (Id_UsesRt && (Ex_Rw == Id_Rt)));

   // First stall cycle comes straight from the IDLE compare; the remaining
   // LOAD_LAT-1 cycles are counted in WAIT independent of ID/EX contents.
   always_comb begin
      w_stall     = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         HZ_IDLE: begin
            w_stall = w_haz && !Flush;
            if (w_stall && (LOAD_LAT > 1)) begin
               w_state_nxt = HZ_WAIT;
               w_cnt_nxt   = LAT_M1;
            end
         end
         HZ_WAIT: begin
            w_stall = !Flush;
            if (Flush || (r_cnt == CNT_1)) begin
               w_state_nxt = HZ_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_1;
            end
         end
         default: begin
            w_state_nxt = HZ_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HZ_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign Pc_Stall   = rst_n & w_stall;
   assign IfId_Stall = rst_n & w_stall;
   assign IdEx_Flush = rst_n & w_stall;

`ifdef HAZ_STATS_EN
   // ---------------- statistics ----------------
   logic [15:0] r_stall_cnt;
   logic [15:0] r_fwd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         // one count per cycle even when both operands are bypassed
         if (((ALUSrcA != 2'b00) || (ALUSrcB != 2'b00)) && (r_fwd_cnt != 16'hFFFF))
            r_fwd_cnt <= r_fwd_cnt + 16'd1;
      end
   end

   assign Stall_Cnt = r_stall_cnt;
   assign Fwd_Cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: two instances share stimulus, one with LOAD_LAT=1, one with LOAD_LAT=3.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Id_Rs, Id_Rt, Ex_Rs, Ex_Rt, Ex_Rw, Mem_Rw, Wr_Rw;
   logic       Id_UsesRt, Ex_MemRead, Mem_RegWr, Wr_RegWr, Flush;

   logic [1:0] a1, b1, d1, a3, b3, d3;
   logic       pc1, ii1, ie1, pc3, ii3, ie3;
`ifdef HAZ_STATS_EN
   logic [15:0] sc1, fc1, sc3, fc3;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
      .Ex_Rs(Ex_Rs), .Ex_Rt(Ex_Rt), .Ex_Rw(Ex_Rw), .Ex_MemRead(Ex_MemRead),
      .Mem_Rw(Mem_Rw), .Mem_RegWr(Mem_RegWr), .Wr_Rw(Wr_Rw), .Wr_RegWr(Wr_RegWr),
      .Flush(Flush), .ALUSrcA(a1), .ALUSrcB(b1), .ALUSrcDin(d1),
      .Pc_Stall(pc1), .IfId_Stall(ii1), .IdEx_Flush(ie1)
`ifdef HAZ_STATS_EN
     ,.Stall_Cnt(sc1), .Fwd_Cnt(fc1)
`endif
   );

   fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
      .Ex_Rs(Ex_Rs), .Ex_Rt(Ex_Rt), .Ex_Rw(Ex_Rw), .Ex_MemRead(Ex_MemRead),
      .Mem_Rw(Mem_Rw), .Mem_RegWr(Mem_RegWr), .Wr_Rw(Wr_Rw), .Wr_RegWr(Wr_RegWr),
      .Flush(Flush), .ALUSrcA(a3), .ALUSrcB(b3), .ALUSrcDin(d3),
      .Pc_Stall(pc3), .IfId_Stall(ii3), .IdEx_Flush(ie3)
`ifdef HAZ_STATS_EN
     ,.Stall_Cnt(sc3), .Fwd_Cnt(fc3)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      Id_Rs = '0; Id_Rt = '0; Id_UsesRt = 1'b0;
      Ex_Rs = '0; Ex_Rt = '0; Ex_Rw = '0; Ex_MemRead = 1'b0;
      Mem_Rw = '0; Mem_RegWr = 1'b0; Wr_Rw = '0; Wr_RegWr = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic set_haz();
      Ex_MemRead = 1'b1; Ex_Rw = 5'd5; Id_Rs = 5'd5;
   endtask

   initial begin
      // reset: outputs low even with matching / hazard inputs present
      rst_n = 1'b0;
      clr();
      Ex_Rs = 5'd3; Mem_Rw = 5'd3; Mem_RegWr = 1'b1;
      set_haz();
      #2;
      chk("rst_srcA",   {14'd0, a1}, 16'h0);
      chk("rst_stall1", {13'd0, pc1, ii1, ie1}, 16'h0);
      chk("rst_stall3", {13'd0, pc3, ii3, ie3}, 16'h0);
      tick();
      tick();
      rst_n = 1'b1;
      clr();
      #1;
      chk("post_rst_stall3", {13'd0, pc3, ii3, ie3}, 16'h0);

      // forwarding: MEM beats WB
      Ex_Rs = 5'd3; Mem_Rw = 5'd3; Mem_RegWr = 1'b1; Wr_Rw = 5'd3; Wr_RegWr = 1'b1;
      #1;
      chk("fwd_mem_prio_A", {14'd0, a1}, 16'h1);
      chk("fwd_mem_prio_B", {14'd0, b1}, 16'h0);
      // WB only when MEM not writing
      Mem_RegWr = 1'b0;
      #1;
      chk("fwd_wb_A", {14'd0, a1}, 16'h2);
      // register zero never forwarded
      clr();
      Ex_Rt = 5'd0; Mem_Rw = 5'd0; Mem_RegWr = 1'b1;
      #1;
      chk("fwd_r0_B",   {14'd0, b1}, 16'h0);
      chk("fwd_r0_Din", {14'd0, d1}, 16'h0);
      // WB match on Rt, MEM targets other reg
      Ex_Rt = 5'd7; Mem_Rw = 5'd2; Wr_Rw = 5'd7; Wr_RegWr = 1'b1;
      #1;
      chk("fwd_wb_B",   {14'd0, b1}, 16'h2);
      chk("fwd_wb_Din", {14'd0, d1}, 16'h2);
      // MEM match on Rt
      Mem_Rw = 5'd7;
      #1;
      chk("fwd_mem_B",  {14'd0, b3}, 16'h1);
      chk("fwd_mem_Din",{14'd0, d3}, 16'h1);
      clr();
      #1;
      chk("fwd_none_A", {14'd0, a3}, 16'h0);

      // load-use, LOAD_LAT=1 vs 3
      tick();
      set_haz();
      #1;
      chk("lu_c1_lat1", {13'd0, pc1, ii1, ie1}, 16'h7);
      chk("lu_c1_lat3", {13'd0, pc3, ii3, ie3}, 16'h7);
      tick();
      clr();
      #1;
      chk("lu_c2_lat1", {13'd0, pc1, ii1, ie1}, 16'h0);
      chk("lu_c2_lat3", {13'd0, pc3, ii3, ie3}, 16'h7);
      tick();
      chk("lu_c3_lat3", {13'd0, pc3, ii3, ie3}, 16'h7);
      tick();
      chk("lu_c4_lat3", {13'd0, pc3, ii3, ie3}, 16'h0);
`ifdef HAZ_STATS_EN
      chk("stall_cnt3", sc3, 16'd3);
      chk("stall_cnt1", sc1, 16'd1);
`endif
      tick();
      chk("lu_c5_lat3", {13'd0, pc3, ii3, ie3}, 16'h0);

      // Rt hazard only when Rt is actually read; r0 loads never stall
      Ex_MemRead = 1'b1; Ex_Rw = 5'd5; Id_Rs = 5'd1; Id_Rt = 5'd5; Id_UsesRt = 1'b0;
      #1;
      chk("rt_unused", {13'd0, pc1, ii1, ie1}, 16'h0);
      Id_UsesRt = 1'b1;
      #1;
      chk("rt_used", {13'd0, pc1, ii1, ie1}, 16'h7);
      clr();
      Ex_MemRead = 1'b1; Ex_Rw = 5'd0; Id_Rs = 5'd0;
      #1;
      chk("haz_r0", {13'd0, pc1, ii1, ie1}, 16'h0);
      Ex_MemRead = 1'b0; Ex_Rw = 5'd5; Id_Rs = 5'd5;
      #1;
      chk("haz_noload", {13'd0, pc1, ii1, ie1}, 16'h0);
      clr();

      // Flush in second stall cycle
      tick();
      set_haz();
      #1;
      chk("fl_c1", {13'd0, pc3, ii3, ie3}, 16'h7);
      tick();
      Flush = 1'b1;
      #1;
      chk("fl_c2_lat3", {13'd0, pc3, ii3, ie3}, 16'h0);
      chk("fl_c2_lat1", {13'd0, pc1, ii1, ie1}, 16'h0);
      tick();
      clr();
      #1;
      chk("fl_idle", {13'd0, pc3, ii3, ie3}, 16'h0);
      // haz + Flush together
      set_haz();
      Flush = 1'b1;
      #1;
      chk("hazfl_lat3", {13'd0, pc3, ii3, ie3}, 16'h0);
      chk("hazfl_lat1", {13'd0, pc1, ii1, ie1}, 16'h0);
      tick();
      clr();
      #1;
      chk("hazfl_next", {13'd0, pc3, ii3, ie3}, 16'h0);

      // async reset mid-WAIT
      set_haz();
      tick();
      clr();
      #1;
      chk("rw_wait", {13'd0, pc3, ii3, ie3}, 16'h7);
      rst_n = 1'b0;
      #1;
      chk("rw_async", {13'd0, pc3, ii3, ie3}, 16'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rw_rel", {13'd0, pc3, ii3, ie3}, 16'h0);
      tick();
      chk("rw_idle", {13'd0, pc3, ii3, ie3}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
